// File: rtl/core_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// core_sequencer_pkg
// Shared definitions for the HighRISC multi-cycle instruction sequencer.
//   seq_state_t  : sequencer FSM state encoding (IDLE..DONE)
//   HALT_OP      : opcode that stops the program
//   MEM_LAT_MAX  : largest data-memory latency the 4-bit wait counter can hold
// -----------------------------------------------------------------------------
package core_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_DONE   = 3'd6
    } seq_state_t;

    localparam logic [2:0] HALT_OP     = 3'b111;
    localparam int         MEM_LAT_MAX = 15;

endpackage

// File: rtl/core_sequencer_perf_counter.sv
// -----------------------------------------------------------------------------
// seq_perf_counter
// Saturating retired-instruction counter. Only instantiated by core_sequencer
// when SEQ_PERF_CNT_EN is defined.
// Parameters:
//   CNTW     counter width
// Ports:
//   Clk      in   core clock, rising edge
//   Reset_n  in   asynchronous active-low reset
//   clr      in   synchronous clear (wins over inc)
//   inc      in   increment by one, holds at all-ones
//   count    out  current count
// -----------------------------------------------------------------------------
module seq_perf_counter #(
    parameter int CNTW = 16
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            clr,
    input  logic            inc,
    output logic [CNTW-1:0] count
);

    logic [CNTW-1:0] r_count;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNTW{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
// Multi-cycle instruction sequencer: FETCH, DECODE, EXEC, optional MEM, WB.
// Turns the decoder's Branch/MemRead/MemWrite/RegWrite levels into single-cycle
// enables for PC, IR, register file and data memory; stops on HALT_OP.
//
// Optional feature: define SEQ_PERF_CNT_EN to get a saturating count of retired
// instructions on InstrCount; otherwise InstrCount is tied to zero.
//
// Parameters:
//   opwidth   opcode width
//   MEM_LAT   data-memory access cycles (1..15)
//   CNTW      InstrCount width
// Ports:
//   Clk, Reset_n            clock (rising), async active-low reset
//   Req / Ack               start level in, program-finished out (DONE)
//   op_code                 opcode from instruction register
//   Branch, MemRead,
//   MemWrite, RegWrite      decoder outputs
//   BranchTaken             ALU branch-condition result
//   IREn, PCEn, PCBranch    IR load, PC advance, PC takes branch target
//   RegWE, LoadWE           register-file write, memory data into R15
//   MemRdEn, MemWrEn        data-memory strobes
//   InstrCount              retired instructions
// -----------------------------------------------------------------------------
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int opwidth = 3,
    parameter int MEM_LAT = 2,
    parameter int CNTW    = 16
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Req,
    output logic               Ack,
    input  logic [opwidth-1:0] op_code,
    input  logic               Branch,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               RegWrite,
    input  logic               BranchTaken,
    output logic               IREn,
    output logic               PCEn,
    output logic               PCBranch,
    output logic               RegWE,
    output logic               LoadWE,
    output logic               MemRdEn,
    output logic               MemWrEn,
    output logic [CNTW-1:0]    InstrCount
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
            $error("core_sequencer: MEM_LAT must be in 1..15");
        end
    endgenerate

    seq_state_t r_state;
    logic [3:0] r_wait;
    logic       w_start;
    logic       w_is_wb;

    // DONE only leaves on a low Req, so a held-high Req cannot restart.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_wait  <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE:   if (Req) r_state <= S_FETCH;
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: r_state <= (op_code == opwidth'(HALT_OP)) ? S_DONE : S_EXEC;
                S_EXEC: begin
                    if (MemRead || MemWrite) begin
                        r_state <= S_MEM;
                        r_wait  <= 4'(MEM_LAT - 1);
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (r_wait == 4'd0) r_state <= S_WB;
                    else                r_wait  <= r_wait - 4'd1;
                end
                S_WB:     r_state <= S_FETCH;
                S_DONE:   if (!Req) r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode from the registered state, so an async reset clears
    // them immediately (including mid-MEM strobes).
    always_comb begin
        Ack      = (r_state == S_DONE);
        IREn     = (r_state == S_FETCH);
        MemRdEn  = (r_state == S_MEM) && MemRead;
        MemWrEn  = (r_state == S_MEM) && MemWrite;
        RegWE    = (r_state == S_WB) && RegWrite;
        LoadWE   = (r_state == S_WB) && MemRead;
        PCEn     = (r_state == S_WB);
        PCBranch = (r_state == S_WB) && Branch && BranchTaken;
    end

    assign w_start = (r_state == S_IDLE) && Req;
    assign w_is_wb = (r_state == S_WB);

`ifdef SEQ_PERF_CNT_EN
    seq_perf_counter #(
        .CNTW (CNTW)
    ) u_perf_cnt (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (w_start),
        .inc     (w_is_wb),
        .count   (InstrCount)
    );
`else
    logic w_unused;
    assign w_unused   = w_start ^ w_is_wb;
    assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
module tb_core_sequencer;
    localparam int CNTW    = 4;
    localparam int MEM_LAT = 2;

    logic            Clk = 1'b0;
    logic            Reset_n;
    logic            Req;
    logic            Ack;
    logic [2:0]      op_code;
    logic            Branch, MemRead, MemWrite, RegWrite, BranchTaken;
    logic            IREn, PCEn, PCBranch, RegWE, LoadWE, MemRdEn, MemWrEn;
    logic [CNTW-1:0] InstrCount;

    core_sequencer #(
        .opwidth (3),
        .MEM_LAT (MEM_LAT),
        .CNTW    (CNTW)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Req         (Req),
        .Ack         (Ack),
        .op_code     (op_code),
        .Branch      (Branch),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .RegWrite    (RegWrite),
        .BranchTaken (BranchTaken),
        .IREn        (IREn),
        .PCEn        (PCEn),
        .PCBranch    (PCBranch),
        .RegWE       (RegWE),
        .LoadWE      (LoadWE),
        .MemRdEn     (MemRdEn),
        .MemWrEn     (MemWrEn),
        .InstrCount  (InstrCount)
    );

    always #5 Clk = ~Clk;

    // {Ack, IREn, PCEn, PCBranch, RegWE, LoadWE, MemRdEn, MemWrEn}
    logic [7:0] w_obs;
    assign w_obs = {Ack, IREn, PCEn, PCBranch, RegWE, LoadWE, MemRdEn, MemWrEn};

    localparam logic [7:0] V_ZERO  = 8'b0000_0000;
    localparam logic [7:0] V_FETCH = 8'b0100_0000;
    localparam logic [7:0] V_DONE  = 8'b1000_0000;

    typedef struct packed {
        logic [7:0]      vec;
        logic [CNTW-1:0] cnt;
    } exp_t;

    exp_t            q[$];
    logic [CNTW-1:0] exp_cnt;
    int              n_tests = 0;
    int              n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        exp_t e;
        e.vec = v;
        e.cnt = exp_cnt;
        q.push_back(e);
    endtask

    task automatic step(input string tag);
        exp_t e;
        @(negedge Clk);
        if (q.size() == 0) begin
            chk({tag, "_qlen"}, 32'(q.size()), 32'd1);
        end else begin
            e = q.pop_front();
            chk({tag, "_out"}, 32'(w_obs), 32'(e.vec));
            chk({tag, "_cnt"}, 32'(InstrCount), 32'(e.cnt));
        end
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) step(tag);
    endtask

    task automatic bump_cnt();
`ifdef SEQ_PERF_CNT_EN
        if (exp_cnt != {CNTW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
`endif
    endtask

    // Expected per-cycle trace of one instruction, straight from the timing
    // rules: FETCH, DECODE, (DONE | EXEC, MEM x MEM_LAT if memory, WB).
    task automatic instr(input string tag, input logic [2:0] op, input logic br,
                         input logic mr, input logic mw, input logic rw,
                         input logic bt, input logic from_idle);
        op_code = op; Branch = br; MemRead = mr; MemWrite = mw;
        RegWrite = rw; BranchTaken = bt;
        if (from_idle) exp_cnt = '0;
        push(V_FETCH);
        push(V_ZERO);
        if (op == 3'b111) begin
            push(V_DONE);
            drain(tag);
        end else begin
            push(V_ZERO);
            if (mr || mw)
                for (int i = 0; i < MEM_LAT; i++) push({6'b0, mr, mw});
            push({2'b00, 1'b1, br & bt, rw, mr, 2'b00});
            drain(tag);
            bump_cnt();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n = 1'b0; Req = 1'b0; op_code = 3'b000;
        Branch = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        RegWrite = 1'b0; BranchTaken = 1'b0;
        exp_cnt = '0;

        #3;
        chk("reset_out", 32'(w_obs), 32'(V_ZERO));
        chk("reset_cnt", 32'(InstrCount), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;

        repeat (3) push(V_ZERO);
        drain("idle");

        Req = 1'b1;
        instr("add",      3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        instr("load",     3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        instr("store",    3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        instr("beq_t",    3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        instr("beq_nt",   3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        instr("add_br_t", 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        instr("halt",     3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Req held high in DONE must not restart.
        repeat (3) push(V_DONE);
        drain("done_hold");
        Req = 1'b0;
        repeat (3) push(V_ZERO);
        drain("done_exit");

        Req = 1'b1;
        for (int i = 0; i < 20; i++)
            instr("add_sat", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (i == 0));
`ifdef SEQ_PERF_CNT_EN
        chk("sat_final", 32'(InstrCount), 32'd15);
`else
        chk("sat_final", 32'(InstrCount), 32'd0);
`endif

        // Store aborted by reset in its first MEM cycle.
        op_code = 3'b011; Branch = 1'b0; MemRead = 1'b0; MemWrite = 1'b1;
        RegWrite = 1'b0; BranchTaken = 1'b0;
        push(V_FETCH); push(V_ZERO); push(V_ZERO); push(8'b0000_0001);
        drain("st_abort");
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rst_async_out", 32'(w_obs), 32'(V_ZERO));
        chk("rst_async_cnt", 32'(InstrCount), 32'd0);
        Req = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        exp_cnt = '0;
        repeat (3) push(V_ZERO);
        drain("post_rst_idle");

        Req = 1'b1;
        instr("add_restart", 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        Req = 1'b0;
        instr("ld_restart",  3'b010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle instruction sequencer for the HighRISC core. It steps every instruction through fetch, decode, execute, optional memory and writeback. It gates the combinational decoder's Branch/MemRead/MemWrite/RegWrite into single-cycle enables for the PC, instruction register, register file and data memory. It sits between the top-level start/done handshake and the datapath, and stops the program on the HALT opcode.

## Interface
Parameters:
- opwidth, 3, opcode width.
- MEM_LAT, 2, data-memory access cycles (legal 1..15).
- CNTW, 16, retired-instruction counter width.

Ports:
- Clk  input  1  core clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Req  input  1  start program; level, sampled in IDLE and DONE.
- Ack  output  1  program finished; high in DONE.
- op_code  input  opwidth  opcode from instruction register.
- Branch, MemRead, MemWrite, RegWrite  input  1 each  decoder outputs.
- BranchTaken  input  1  ALU branch-condition result.
- IREn  output  1  load instruction register.
- PCEn  output  1  advance PC.
- PCBranch  output  1  PC takes branch target (valid only with PCEn).
- RegWE  output  1  register-file write enable.
- LoadWE  output  1  write memory data into R15.
- MemRdEn, MemWrEn  output  1 each  data-memory strobes.
- InstrCount  output  CNTW  retired instructions; see Configuration.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, DONE.
- IDLE: all enables low. Req=1 moves to FETCH.
- FETCH: IREn=1 for one cycle, then DECODE.
- DECODE: op_code==HALT_OP (3'b111) moves to DONE. Otherwise moves to EXEC.
- EXEC: one ALU cycle. MemRead|MemWrite moves to MEM. Otherwise moves to WB.
- MEM:
  - MemRdEn=MemRead and MemWrEn=MemWrite, held for exactly MEM_LAT cycles.
  - A 4-bit wait counter loads MEM_LAT-1 on entry and decrements each cycle.
  - At 0 it moves to WB.
- WB:
  - RegWE=RegWrite. LoadWE=MemRead.
  - PCEn=1 and PCBranch=Branch&BranchTaken.
  - Then FETCH.
- DONE: Ack=1. Stays until Req=0, then IDLE. Req held high never restarts the program without a low phase.
- Req changes outside IDLE/DONE are ignored.
- Branch and store instructions still pass WB. PCEn fires with RegWE=0.

## Timing
- Reset (async assert, any state): state=IDLE; all outputs 0; wait counter 0; InstrCount 0. Deassertion is synchronized by the system; the first edge after deassertion evaluates IDLE.
- All outputs are Moore, decoded from the registered state. Decoder inputs are sampled combinationally in the state that uses them, and must be stable from DECODE onward.
- ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
- Load/store: 4+MEM_LAT cycles.
- HALT: 2 cycles to DONE (FETCH, DECODE). PC does not advance on HALT.
- Req=1 in IDLE at edge n: IREn high in cycle n+1.
- Reset mid-MEM aborts the access; MemRdEn/MemWrEn drop immediately (async).
- MEM_LAT outside 1..15 is a compile-time error ($error in an initial/generate check).

## Configuration
- SEQ_PERF_CNT_EN defined:
  - InstrCount increments by 1 on every WB cycle.
  - Saturates at all-ones.
  - Clears on reset and on the IDLE→FETCH transition.
- Undefined: InstrCount tied to 0 and no counter flops exist. All other behaviour is identical.

## Structure
- Definitions package gets:
  - seq_state_t: enum logic [2:0] covering IDLE..DONE.
  - HALT_OP = 3'b111.
  - MEM_LAT_MAX = 15.
- Single FSM module. The saturating counter is a natural sub-module, seq_perf_counter (params CNTW; ports Clk, Reset_n, clr, inc, count), instantiated only under SEQ_PERF_CNT_EN.

## Test plan
- Reset, then Req=1, with ADD (op 000, RegWrite=1): IREn at cycle 1, RegWE and PCEn at cycle 4, PCBranch=0. InstrCount=1 with macro.
- Load (op 010, MEM_LAT=2): MemRdEn high cycles 4–5, LoadWE=1 and RegWE=0 at cycle 6, then FETCH.
- BEQ (op 101): with BranchTaken=1, WB gives PCEn=1 and PCBranch=1. With BranchTaken=0, PCBranch=0. RegWE=0 in both.
- HALT (op 111): DONE after DECODE, Ack=1, PCEn never asserted. Ack held while Req=1. Req=0 returns to IDLE with Ack=0 next cycle.
- Reset_n pulsed low mid-MEM of a store: MemWrEn and every other output 0 immediately. After release, the core stays in IDLE until Req rises.
- Macro build with CNTW=4, 20 ADDs: InstrCount saturates at 15. Non-macro build: InstrCount=0 throughout.
